bf16_spi_master: RTL and testbench

- SPI master that drives the bfloat16 processor's SPI slave port. It accepts one command from local logic (opcode plus up to two bfloat16 operands) and serialises it as separate 16-bit chip-select frames.
- Optionally runs a trailing readback frame and returns the slave's 16-bit result.
- Sits on the host/controller side of the SPI link, one instance per processor.

---
 rtl/bf16_spi_pkg.sv | 39 +++
 rtl/spi_frame_engine.sv | 132 +++++++++++++
 rtl/bf16_spi_master.sv | 158 +++++++++++++++
 tb/tb_bf16_spi_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_spi_pkg.sv
// Shared definitions for the bfloat16 processor SPI master: opcodes, word width,
// FSM state encodings and the operand-count helper.
package bf16_spi_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_ZERO     = 4'd0;
    localparam logic [3:0] OP_SET_ACC  = 4'd1;
    localparam logic [3:0] OP_LOAD_ACC = 4'd2;
    localparam logic [3:0] OP_ADD2     = 4'd3;
    localparam logic [3:0] OP_SUB2     = 4'd4;
    localparam logic [3:0] OP_MPY2     = 4'd5;
    localparam logic [3:0] OP_DIV2     = 4'd6;
    localparam logic [3:0] OP_SUM      = 4'd7;
    localparam logic [3:0] OP_SUB      = 4'd8;
    localparam logic [3:0] OP_MAC      = 4'd9;
    localparam logic [3:0] OP_MAS      = 4'd10;

    typedef enum logic [2:0] {
        E_IDLE,
        E_LOAD,
        E_SHIFT_LO,
        E_SHIFT_HI,
        E_HOLD
    } eng_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_GAP,
        S_FINISH
    } seq_state_e;

    // Only the two-operand arithmetic opcodes carry operand_b on the wire.
    function automatic logic needs_two_operands(input logic [3:0] opcode);
        return (opcode >= OP_ADD2) && (opcode <= OP_DIV2);
    endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// One full-duplex 16-bit SPI frame, LSB first: SCK generation, cs_n framing and
// MOSI/MISO shifting. sck, mosi and cs_n come straight from flops.
module spi_frame_engine
    import bf16_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    output logic              frame_done,
    output logic [WORD_W-1:0] word_out,
    output logic              sck,
    output logic              mosi,
    output logic              cs_n,
    input  logic              miso
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    eng_state_e        state_r, state_s;
    logic [DIV_W-1:0]  div_r, div_s;
    logic [3:0]        bit_r, bit_s;
    logic [WORD_W-1:0] tx_r, tx_s;
    logic [WORD_W-1:0] rx_r, rx_s;
    logic              sck_r, mosi_r, cs_n_r;
    logic              frame_done_s;
    logic              phase_end_s;
    logic              shifting_s;
    logic              framing_s;

    assign phase_end_s = (div_r == '0);

    // Next-state, divider, bit counter and shift-register updates.
    always_comb begin
        state_s      = state_r;
        div_s        = div_r;
        bit_s        = bit_r;
        tx_s         = tx_r;
        rx_s         = rx_r;
        frame_done_s = 1'b0;
        case (state_r)
            E_IDLE: begin
                if (load) begin
                    state_s = E_LOAD;
                end else begin
                    state_s = E_IDLE;
                end
            end
            E_LOAD: begin
                tx_s    = word_in;
                bit_s   = 4'd0;
                div_s   = DIV_RELOAD;
                state_s = E_SHIFT_LO;
            end
            E_SHIFT_LO: begin
                if (phase_end_s) begin
                    div_s   = DIV_RELOAD;
                    state_s = E_SHIFT_HI;
                end else begin
                    div_s = div_r - DIV_W'(1);
                end
            end
            E_SHIFT_HI: begin
                // First HI cycle is the SCK rising edge seen by the slave.
                if (div_r == DIV_RELOAD) begin
                    rx_s = {miso, rx_r[WORD_W-1:1]};
                end else begin
                    rx_s = rx_r;
                end
                if (phase_end_s) begin
                    div_s = DIV_RELOAD;
                    tx_s  = {1'b0, tx_r[WORD_W-1:1]};
                    bit_s = bit_r + 4'd1;
                    if (bit_r == 4'd15) begin
                        state_s = E_HOLD;
                    end else begin
                        state_s = E_SHIFT_LO;
                    end
                end else begin
                    div_s = div_r - DIV_W'(1);
                end
            end
            E_HOLD: begin
                if (phase_end_s) begin
                    frame_done_s = 1'b1;
                    state_s      = E_IDLE;
                end else begin
                    div_s = div_r - DIV_W'(1);
                end
            end
            default: begin
                state_s = E_IDLE;
            end
        endcase
    end

    assign shifting_s = (state_s == E_SHIFT_LO) || (state_s == E_SHIFT_HI);
    assign framing_s  = shifting_s || (state_s == E_HOLD);

    // State and pin registers; pins are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= E_IDLE;
            div_r   <= '0;
            bit_r   <= 4'd0;
            tx_r    <= '0;
            rx_r    <= '0;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            cs_n_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            rx_r    <= rx_s;
            sck_r   <= (state_s == E_SHIFT_HI);
            mosi_r  <= shifting_s ? tx_s[0] : 1'b0;
            cs_n_r  <= !framing_s;
        end
    end

    assign frame_done = frame_done_s;
    assign word_out   = rx_r;
    assign sck        = sck_r;
    assign mosi       = mosi_r;
    assign cs_n       = cs_n_r;

endmodule

// File: rtl/bf16_spi_master.sv
// Host-side SPI master for the bfloat16 processor: sequences the opcode, operand
// and optional readback frames of one command and separates them by a cs_n gap.
module bf16_spi_master
    import bf16_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [WORD_W-1:0] operand_a,
    input  logic [WORD_W-1:0] operand_b,
    input  logic              read_result,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              sck,
    output logic              mosi,
    output logic              cs_n,
    input  logic              miso
);

    localparam int GAP_W = $clog2(CS_GAP) + 1;
    // The engine's LOAD cycle also keeps cs_n high, so it is the last gap cycle.
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CS_GAP - 2);

    seq_state_e        seq_r, seq_s;
    logic [GAP_W-1:0]  gap_r, gap_s;
    logic [1:0]        idx_r, idx_s;
    logic [3:0]        op_r;
    logic [WORD_W-1:0] a_r, b_r;
    logic              rr_r;
    logic [WORD_W-1:0] result_r;
    logic              busy_r, done_r;
    logic              load_s;
    logic              two_s;
    logic              is_rb_s;
    logic [1:0]        last_idx_s;
    logic [WORD_W-1:0] word_s;
    logic              frame_done_s;
    logic [WORD_W-1:0] word_out_s;

    assign two_s      = needs_two_operands(op_r);
    assign last_idx_s = 2'd1 + {1'b0, two_s} + {1'b0, rr_r};
    assign is_rb_s    = (idx_r == 2'd3) || ((idx_r == 2'd2) && !two_s);

    // Word for the frame at idx_r; the readback frame sends zeros.
    always_comb begin
        word_s = '0;
        case (idx_r)
            2'd0:    word_s = {12'h000, op_r};
            2'd1:    word_s = a_r;
            2'd2:    word_s = two_s ? b_r : 16'h0000;
            default: word_s = 16'h0000;
        endcase
    end

    // Frame sequencer next-state and engine load request.
    always_comb begin
        seq_s  = seq_r;
        gap_s  = gap_r;
        idx_s  = idx_r;
        load_s = 1'b0;
        case (seq_r)
            S_IDLE: begin
                if (start) begin
                    seq_s  = S_FRAME;
                    idx_s  = 2'd0;
                    load_s = 1'b1;
                end else begin
                    seq_s = S_IDLE;
                end
            end
            S_FRAME: begin
                if (frame_done_s) begin
                    seq_s = S_GAP;
                    gap_s = GAP_RELOAD;
                end else begin
                    seq_s = S_FRAME;
                end
            end
            S_GAP: begin
                if (gap_r != '0) begin
                    gap_s = gap_r - GAP_W'(1);
                end else if (idx_r == last_idx_s) begin
                    seq_s = S_FINISH;
                end else begin
                    idx_s  = idx_r + 2'd1;
                    load_s = 1'b1;
                    seq_s  = S_FRAME;
                end
            end
            S_FINISH: begin
                seq_s = S_IDLE;
            end
            default: begin
                seq_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, command latch, result capture and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_r    <= S_IDLE;
            gap_r    <= '0;
            idx_r    <= 2'd0;
            op_r     <= 4'd0;
            a_r      <= '0;
            b_r      <= '0;
            rr_r     <= 1'b0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            seq_r  <= seq_s;
            gap_r  <= gap_s;
            idx_r  <= idx_s;
            busy_r <= (seq_s == S_FRAME) || (seq_s == S_GAP);
            done_r <= (seq_s == S_FINISH);
            if ((seq_r == S_IDLE) && start) begin
                op_r <= opcode;
                a_r  <= operand_a;
                b_r  <= operand_b;
                rr_r <= read_result;
            end else begin
                op_r <= op_r;
            end
            if ((seq_r == S_FRAME) && frame_done_s && is_rb_s) begin
                result_r <= word_out_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    spi_frame_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .word_in    (word_s),
        .frame_done (frame_done_s),
        .word_out   (word_out_s),
        .sck        (sck),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso)
    );

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_bf16_spi_master.sv
// Self-checking bench for bf16_spi_master: an SPI slave model decodes MOSI frames
// against a scoreboard of expected words and answers each frame from a reply queue.
module tb_bf16_spi_master;
    import bf16_spi_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 8;
    localparam int BUDGET  = 4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] operand_a = 16'h0000;
    logic [15:0] operand_b = 16'h0000;
    logic        read_result = 1'b0;
    logic        miso = 1'b0;
    logic        busy, done, sck, mosi, cs_n;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [15:0] resp_q[$];
    logic [15:0] exp_result = 16'h0000;
    int          frames_seen = 0;

    logic        prev_cs = 1'b1, prev_sck = 1'b0, in_frame = 1'b0, gap_valid = 1'b0;
    logic        mosi_at_rise = 1'b0;
    int          low_cnt = 0, rises = 0, gap_cnt = 0, stab_err = 0;
    logic [15:0] rxw = 16'h0000, cur_resp = 16'hFFFF, want_w;

    always #5 clk = ~clk;

    bf16_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .read_result(read_result),
        .busy(busy), .done(done), .result(result),
        .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
    );

    // Slave model and frame monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sck = 1'b0; in_frame = 1'b0; gap_valid = 1'b0; miso = 1'b0;
        end else begin
            if (done) gap_valid = 1'b0;
            if (prev_cs && !cs_n) begin
                if (gap_valid) begin
                    checks++;
                    if (gap_cnt != CS_GAP) begin
                        errors++;
                        $display("FAIL gap_len: cs_n high %0d cycles, want %0d", gap_cnt, CS_GAP);
                    end
                end
                in_frame = 1'b1; low_cnt = 0; rises = 0; rxw = 16'h0000; stab_err = 0;
                if (resp_q.size() > 0) cur_resp = resp_q.pop_front();
                else cur_resp = 16'hFFFF;
            end
            if (!cs_n) low_cnt++;
            if (!cs_n && !prev_sck && sck) begin
                if (rises < 16) rxw[rises] = mosi;
                mosi_at_rise = mosi;
                rises++;
            end else if (!cs_n && sck && (mosi !== mosi_at_rise)) begin
                stab_err++;
            end
            if (!prev_cs && cs_n && in_frame) begin
                in_frame = 1'b0;
                frames_seen++;
                gap_cnt = 0;
                gap_valid = 1'b1;
                checks++;
                if (low_cnt != 33 * CLK_DIV) begin
                    errors++;
                    $display("FAIL cs_low_len: %0d cycles, want %0d", low_cnt, 33 * CLK_DIV);
                end
                checks++;
                if (rises != 16) begin
                    errors++;
                    $display("FAIL sck_rises: %0d, want 16", rises);
                end
                checks++;
                if (stab_err != 0) begin
                    errors++;
                    $display("FAIL mosi_stable: %0d changes while sck high, want 0", stab_err);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_word: unexpected frame %h, none expected", rxw);
                end else begin
                    want_w = exp_q.pop_front();
                    if (rxw !== want_w) begin
                        errors++;
                        $display("FAIL frame_word: got %h, want %h", rxw, want_w);
                    end
                end
            end
            if (cs_n) gap_cnt++;
            if (!cs_n && !sck && rises < 16) miso = cur_resp[rises];
            prev_cs = cs_n;
            prev_sck = sck;
        end
    end

    task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic rr, input logic [15:0] rb, output logic [15:0] want);
        exp_q.push_back({12'h000, op});
        resp_q.push_back(16'h9000);
        exp_q.push_back(a);
        resp_q.push_back(16'h9001);
        if (needs_two_operands(op)) begin
            exp_q.push_back(b);
            resp_q.push_back(16'h9002);
        end
        if (rr) begin
            exp_q.push_back(16'h0000);
            resp_q.push_back(rb);
            exp_result = rb;
        end
        want = exp_result;
    endtask

    task automatic run_cmd(input string name, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic rr, input logic [15:0] rb,
                           input int glitch_at);
        logic [15:0] want;
        int nf, f0, cyc;
        nf = 2 + (needs_two_operands(op) ? 1 : 0) + (rr ? 1 : 0);
        push_cmd(op, a, b, rr, rb, want);
        f0 = frames_seen;
        @(negedge clk);
        opcode = op; operand_a = a; operand_b = b; read_result = rr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b, want 1", name, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitch_at) begin
                start = 1'b1; opcode = OP_ADD2; operand_a = 16'hDEAD;
                operand_b = 16'hBEEF; read_result = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, BUDGET);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
        end
        checks++;
        if (result !== want) begin
            errors++;
            $display("FAIL %s result: got %h, want %h", name, result, want);
        end
        checks++;
        if (frames_seen - f0 != nf) begin
            errors++;
            $display("FAIL %s frame_count: got %0d, want %0d", name, frames_seen - f0, nf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done still %b one cycle later, want 0", name, done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover_frames: %0d expected frames not seen, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sck, mosi, cs_n, busy, done} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_pins: sck,mosi,cs_n,busy,done=%b, want 00100", {sck, mosi, cs_n, busy, done});
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result: got %h, want 0000", result);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mpy2_readback();
        run_cmd("mpy2_rb", OP_MPY2, 16'h3F80, 16'h4000, 1'b1, 16'h4000, -1);
    endtask

    task automatic test_set_acc_no_readback();
        run_cmd("set_acc", OP_SET_ACC, 16'h4120, 16'h7F7F, 1'b0, 16'h0000, -1);
    endtask

    task automatic test_frame_timing();
        run_cmd("add2_timing", OP_ADD2, 16'h4049, 16'h402D, 1'b1, 16'h40B6, -1);
        run_cmd("op11_single", 4'd11, 16'h1234, 16'hFFFF, 1'b1, 16'h2468, -1);
    endtask

    task automatic test_start_while_busy();
        run_cmd("busy_ignore", OP_LOAD_ACC, 16'hC2A0, 16'h0000, 1'b0, 16'h0000, 100);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] want;
        int f0, cyc, dcnt;
        push_cmd(OP_SET_ACC, 16'h4120, 16'h0000, 1'b1, 16'h7777, want);
        f0 = frames_seen;
        @(negedge clk);
        opcode = OP_SET_ACC; operand_a = 16'h4120; read_result = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(frames_seen - f0 == 1 && in_frame && rises == 7) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= BUDGET) begin
            errors++;
            $display("FAIL rst_mid reach_bit7: W1 bit 7 not reached in %0d cycles", BUDGET);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n, sck, busy, done} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid pins: cs_n,sck,busy,done=%b, want 1000", {cs_n, sck, busy, done});
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid result: got %h, want 0000", result);
        end
        exp_q.delete();
        resp_q.delete();
        exp_result = 16'h0000;
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL rst_mid no_done: saw %0d done cycles, want 0", dcnt);
        end
        run_cmd("after_reset", OP_MAC, 16'h3C00, 16'h0000, 1'b1, 16'h1357, -1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1, w2;
        int f0, cyc, gap_n;
        push_cmd(OP_SUB2, 16'h4040, 16'h3F80, 1'b1, 16'h4000, w1);
        push_cmd(OP_SUM, 16'h3F00, 16'h0000, 1'b1, 16'hC0DE, w2);
        f0 = frames_seen;
        @(negedge clk);
        opcode = OP_SUB2; operand_a = 16'h4040; operand_b = 16'h3F80; read_result = 1'b1; start = 1'b1;
        @(negedge clk);
        opcode = OP_SUM; operand_a = 16'h3F00; operand_b = 16'h0000;
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || result !== w1) begin
            errors++;
            $display("FAIL b2b result1: done=%b result=%h, want done=1 result=%h", done, result, w1);
        end
        gap_n = 0;
        do begin
            @(negedge clk);
            gap_n++;
            if (gap_n == 2) start = 1'b0;
        end while (cs_n && gap_n < 100);
        start = 1'b0;
        checks++;
        if (cs_n !== 1'b0 || gap_n < 2) begin
            errors++;
            $display("FAIL b2b restart: cs_n=%b fell %0d cycles after done, want 0 and >=2", cs_n, gap_n);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || result !== w2) begin
            errors++;
            $display("FAIL b2b result2: done=%b result=%h, want done=1 result=%h", done, result, w2);
        end
        @(negedge clk);
        checks++;
        if (frames_seen - f0 != 7 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b frames: got %0d frames, %0d left, want 7 and 0", frames_seen - f0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mpy2_readback();
        test_set_acc_no_readback();
        test_frame_timing();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
